lsd_seq_ctrl: RTL and testbench

//  Multi-cycle fetch/execute sequencer for the 8-bit LSD datapath (regs A,R1..R3, FLAGS, ALU, 32x8 ROM).

---
 rtl/lsd_seq_ctrl_pkg.sv | 31 +++
 rtl/lsd_seq_ctrl_if.sv | 31 +++
 rtl/lsd_seq_ctrl_dec24.sv | 13 +
 rtl/lsd_seq_ctrl.sv | 117 +++++++++++
 tb/tb_lsd_seq_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsd_seq_ctrl_pkg.sv
// rtl/lsd_seq_ctrl_pkg.sv - shared types and defaults for the LSD fetch/execute sequencer
// Purpose: sequencer state encoding, instruction field layout and default opcodes.
// Ports: none (package).
package lsd_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  // Instruction byte: OPR=[7:5], SEL=[4:2], CE=[1:0]; a jump reuses {SEL,CE} as its target.
  typedef struct packed {
    logic [2:0] opr;
    logic [2:0] sel;
    logic [1:0] ce;
  } instr_t;

  localparam int         AW_DEFAULT        = 5;
  localparam int         LAST_ADDR_DEFAULT = 31;
  localparam logic [2:0] JMP_OPR_DEFAULT   = 3'b101;
  localparam logic [2:0] X_SEL_DEFAULT     = 3'b100;
  localparam int         CNT_W_DEFAULT     = 16;

  function automatic logic [4:0] jump_target(input instr_t ir);
    return {ir.sel, ir.ce};
  endfunction

endpackage

// File: rtl/lsd_seq_ctrl_if.sv
// rtl/lsd_seq_ctrl_if.sv - sequencer <-> datapath/ROM/X-source bus
// Purpose: bundles ROM access, ALU/B-mux control, write enables and the X handshake.
// Ports (master = sequencer):
//   out rom_addr, opr, sel, en_a, en_r1, en_r2, en_r3, en_flags, x_ready
//   in  rom_data, flag_z, x_valid
interface lsd_seq_ctrl_if #(
  parameter int AW = 5
);
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [2:0]    opr;
  logic [2:0]    sel;
  logic          en_a;
  logic          en_r1;
  logic          en_r2;
  logic          en_r3;
  logic          en_flags;
  logic          flag_z;
  logic          x_valid;
  logic          x_ready;

  modport master (
    output rom_addr, opr, sel, en_a, en_r1, en_r2, en_r3, en_flags, x_ready,
    input  rom_data, flag_z, x_valid
  );

  modport slave (
    input  rom_addr, opr, sel, en_a, en_r1, en_r2, en_r3, en_flags, x_ready,
    output rom_data, flag_z, x_valid
  );
endinterface

// File: rtl/lsd_seq_ctrl_dec24.sv
// rtl/lsd_seq_ctrl_dec24.sv - 2-to-4 one-hot decoder with enable
// Purpose: turns the CE field into one register write enable.
// Ports: en (in), code[1:0] (in), y[3:0] (out, one-hot or zero).
module lsd_seq_ctrl_dec24 (
  input  logic       en,
  input  logic [1:0] code,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    if (en) y[code] = 1'b1;
  end
endmodule

// File: rtl/lsd_seq_ctrl.sv
// rtl/lsd_seq_ctrl.sv - multi-cycle fetch/execute sequencer for the LSD datapath
// Purpose: owns PC, IR and retired-instruction counter; runs FETCH/EXEC with
//   start/stop/single-step control and stalls EXEC until operand X is valid.
// Ports:
//   clock, reset (sync, active-high)
//   start, stop, step (pulses), run_mode (1=free run, 0=single step)
//   bus (master): ROM address/data, opr/sel, write enables, flag_z, X handshake
//   busy, halted, instr_cnt (status)
module lsd_seq_ctrl
  import lsd_seq_ctrl_pkg::*;
#(
  parameter int         AW        = AW_DEFAULT,
  parameter int         LAST_ADDR = LAST_ADDR_DEFAULT,
  parameter logic [2:0] JMP_OPR   = JMP_OPR_DEFAULT,
  parameter logic [2:0] X_SEL     = X_SEL_DEFAULT,
  parameter int         CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             run_mode,
  input  logic             step,
  lsd_seq_ctrl_if.master   bus,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t        state;
  logic [AW-1:0] pc;
  instr_t        ir;
  logic          stop_pend;

  logic          is_jump;
  logic          uses_x;
  logic          retire;
  logic          exec_en;
  logic [AW-1:0] pc_next;
  logic [3:0]    ce_onehot;

  assign is_jump = (ir.opr == JMP_OPR);
  assign uses_x  = (ir.sel == X_SEL);

  // EXEC retires unless a non-jump reads X before it is valid. Reset masks the
  // retire so an aborted instruction never writes the datapath.
  assign retire  = (state == ST_EXEC) && !reset && (is_jump || !uses_x || bus.x_valid);
  assign exec_en = retire && !is_jump;

  assign pc_next = (is_jump && !bus.flag_z) ? AW'(jump_target(ir)) : pc + AW'(1);

  lsd_seq_ctrl_dec24 u_ce_dec (
    .en   (exec_en),
    .code (ir.ce),
    .y    (ce_onehot)
  );

  assign bus.rom_addr = pc;
  assign bus.opr      = ir.opr;
  assign bus.sel      = ir.sel;
  assign bus.en_a     = ce_onehot[0];
  assign bus.en_r1    = ce_onehot[1];
  assign bus.en_r2    = ce_onehot[2];
  assign bus.en_r3    = ce_onehot[3];
  assign bus.en_flags = exec_en;
  assign bus.x_ready  = exec_en && uses_x;

  assign busy   = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_STEP_WAIT);
  assign halted = (state == ST_HALTED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      instr_cnt <= '0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state     <= ST_FETCH;
            pc        <= '0;
            instr_cnt <= '0;
            stop_pend <= 1'b0;
          end
        end

        ST_FETCH: begin
          ir    <= instr_t'(bus.rom_data);
          state <= ST_EXEC;
          if (stop) stop_pend <= 1'b1;
        end

        ST_EXEC: begin
          if (stop) stop_pend <= 1'b1;
          if (retire) begin
            pc <= pc_next;
            if (instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
            // Halt test uses the PC of the instruction just executed.
            if (stop_pend || stop || (pc == AW'(LAST_ADDR))) state <= ST_HALTED;
            else if (run_mode)                                state <= ST_FETCH;
            else                                              state <= ST_STEP_WAIT;
          end
        end

        ST_STEP_WAIT: begin
          if (stop)      state <= ST_HALTED;
          else if (step) state <= ST_FETCH;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsd_seq_ctrl.sv
// tb/tb_lsd_seq_ctrl.sv - self-checking bench for lsd_seq_ctrl
module tb_lsd_seq_ctrl;
  import lsd_seq_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        run_mode = 1'b1;
  logic        step = 1'b0;
  logic        busy;
  logic        halted;
  logic [15:0] instr_cnt;
  logic [7:0]  rom [32];

  int compared = 0;
  int mismatched = 0;

  lsd_seq_ctrl_if #(.AW(5)) bus ();

  lsd_seq_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .run_mode  (run_mode),
    .step      (step),
    .bus       (bus),
    .busy      (busy),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  always #5 clock = ~clock;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] en_vec();
    return {bus.en_r3, bus.en_r2, bus.en_r1, bus.en_a};
  endfunction

  function automatic logic [7:0] plain_instr(input bit allow_x);
    logic [2:0] o;
    logic [2:0] s;
    logic [1:0] c;
    o = 3'($urandom_range(0, 7));
    if (o == 3'b101) o = 3'b000;
    s = 3'($urandom_range(0, 7));
    if (!allow_x && s == 3'b100) s = 3'b000;
    c = 2'($urandom_range(0, 3));
    return {o, s, c};
  endfunction

  task automatic fill_rom(input bit jumps, input bit allow_x);
    for (int p = 0; p < 32; p++) begin
      if (jumps && p < 30 && $urandom_range(0, 3) == 0)
        rom[p] = {3'b101, 5'($urandom_range(p + 1, 31))};
      else
        rom[p] = plain_instr(allow_x);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    bus.x_valid = 1'b0; bus.flag_z = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom(0, 0);
    do_reset();
    #1;
    compared++;
    if ({busy, halted, en_vec(), bus.en_flags, bus.x_ready} !== 8'b0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {busy, halted, en_vec(), bus.en_flags, bus.x_ready});
    end
    compared++;
    if (bus.rom_addr !== 5'd0 || instr_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_pc_cnt got pc=%0d cnt=%0d want 0/0", bus.rom_addr, instr_cnt);
    end
    compared++;
    if ({bus.opr, bus.sel} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ir got=%b want=000000", {bus.opr, bus.sel});
    end
  endtask

  task automatic test_first_fetch();
    fill_rom(0, 0);
    rom[0] = 8'h00;
    run_mode = 1'b1;
    do_reset();
    start = 1'b1; tick(); start = 1'b0; #1;
    compared++;
    if (busy !== 1'b1 || en_vec() !== 4'b0 || bus.en_flags !== 1'b0 || bus.rom_addr !== 5'd0) begin
      mismatched++;
      $display("FAIL fetch_state got busy=%b en=%b f=%b pc=%0d want 1/0000/0/0",
               busy, en_vec(), bus.en_flags, bus.rom_addr);
    end
    tick(); #1;
    compared++;
    if (en_vec() !== 4'b0001 || bus.en_flags !== 1'b1 || bus.x_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL exec_en_a got en=%b f=%b xr=%b want 0001/1/0", en_vec(), bus.en_flags, bus.x_ready);
    end
    tick(); #1;
    compared++;
    if (bus.rom_addr !== 5'd1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL first_pc got pc=%0d busy=%b want 1/1", bus.rom_addr, busy);
    end
  endtask

  task automatic test_jump();
    logic [4:0] want;
    for (int fz = 0; fz < 2; fz++) begin
      fill_rom(0, 0);
      rom[0] = 8'hB1;
      run_mode = 1'b1;
      do_reset();
      bus.flag_z = 1'(fz);
      start = 1'b1; tick(); start = 1'b0;
      tick(); #1;
      compared++;
      if (en_vec() !== 4'b0 || bus.en_flags !== 1'b0 || bus.x_ready !== 1'b0 || bus.opr !== 3'b101) begin
        mismatched++;
        $display("FAIL jump_no_enables fz=%0d got en=%b f=%b xr=%b opr=%b want 0000/0/0/101",
                 fz, en_vec(), bus.en_flags, bus.x_ready, bus.opr);
      end
      tick(); #1;
      want = (fz == 0) ? 5'd17 : 5'd1;
      compared++;
      if (bus.rom_addr !== want) begin
        mismatched++;
        $display("FAIL jump_target fz=%0d got pc=%0d want %0d", fz, bus.rom_addr, want);
      end
    end
  endtask

  task automatic test_x_stall();
    fill_rom(0, 0);
    rom[0] = 8'h11;
    run_mode = 1'b1;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++;
      if (en_vec() !== 4'b0 || bus.en_flags !== 1'b0 || bus.x_ready !== 1'b0 ||
          bus.rom_addr !== 5'd0 || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL x_stall cyc=%0d got en=%b f=%b xr=%b pc=%0d busy=%b want 0000/0/0/0/1",
                 i, en_vec(), bus.en_flags, bus.x_ready, bus.rom_addr, busy);
      end
      tick();
    end
    bus.x_valid = 1'b1; #1;
    compared++;
    if (en_vec() !== 4'b0010 || bus.en_flags !== 1'b1 || bus.x_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL x_consume got en=%b f=%b xr=%b want 0010/1/1", en_vec(), bus.en_flags, bus.x_ready);
    end
    tick(); bus.x_valid = 1'b0; #1;
    compared++;
    if (bus.rom_addr !== 5'd1) begin
      mismatched++;
      $display("FAIL x_pc_after got pc=%0d want 1", bus.rom_addr);
    end
  endtask

  task automatic test_single_step();
    fill_rom(0, 0);
    run_mode = 1'b0;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    for (int k = 1; k <= 2; k++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        #1;
        compared++;
        if (busy !== 1'b1 || en_vec() !== 4'b0 || bus.en_flags !== 1'b0 ||
            bus.rom_addr !== 5'(k) || instr_cnt !== 16'(k)) begin
          mismatched++;
          $display("FAIL step_wait k=%0d got busy=%b en=%b pc=%0d cnt=%0d want 1/0000/%0d/%0d",
                   k, busy, en_vec(), bus.rom_addr, instr_cnt, k, k);
        end
        tick();
      end
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick();
    end
    #1;
    compared++;
    if (instr_cnt !== 16'd3 || bus.rom_addr !== 5'd3 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL step_count got cnt=%0d pc=%0d busy=%b want 3/3/1", instr_cnt, bus.rom_addr, busy);
    end
    step = 1'b1; stop = 1'b1; tick(); step = 1'b0; stop = 1'b0; #1;
    compared++;
    if (halted !== 1'b1 || busy !== 1'b0 || instr_cnt !== 16'd3 || bus.rom_addr !== 5'd3) begin
      mismatched++;
      $display("FAIL step_stop got halted=%b busy=%b cnt=%0d pc=%0d want 1/0/3/3",
               halted, busy, instr_cnt, bus.rom_addr);
    end
    run_mode = 1'b1;
  endtask

  // Reference: walk the ROM at instruction level to get the list of retired
  // (pc, next pc) pairs, then match every observed PC change against it.
  task automatic run_program(input logic fz, input int tag);
    int         tr_pc[$];
    int         tr_next[$];
    int         p;
    int         nxt;
    int         idx;
    int         cycles;
    logic [7:0] ins;
    logic [4:0] a0;
    logic [3:0] env;
    logic [3:0] exp_en;
    logic       ef;
    logic       xr;
    logic       exp_f;
    logic       exp_x;
    p = 0;
    for (int g = 0; g < 200; g++) begin
      ins = rom[p];
      if (ins[7:5] == 3'b101 && !fz) nxt = int'(ins[4:0]);
      else nxt = (p + 1) % 32;
      tr_pc.push_back(p);
      tr_next.push_back(nxt);
      if (p == 31) break;
      p = nxt;
    end
    bus.flag_z = fz;
    run_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    idx = 0;
    cycles = 0;
    while (halted !== 1'b1 && cycles < 3000) begin
      bus.x_valid = 1'($urandom_range(0, 1)); #1;
      a0 = bus.rom_addr; env = en_vec(); ef = bus.en_flags; xr = bus.x_ready;
      tick();
      cycles++;
      compared++;
      if (bus.rom_addr !== a0) begin
        if (idx >= tr_pc.size()) begin
          mismatched++;
          $display("FAIL run%0d_extra_retire pc=%0d want no retire", tag, a0);
        end else begin
          ins = rom[tr_pc[idx]];
          exp_f = (ins[7:5] != 3'b101);
          exp_en = exp_f ? (4'b0001 << ins[1:0]) : 4'b0000;
          exp_x = exp_f && (ins[4:2] == 3'b100);
          if ({a0, env, ef, xr, bus.rom_addr} !==
              {5'(tr_pc[idx]), exp_en, exp_f, exp_x, 5'(tr_next[idx])}) begin
            mismatched++;
            $display("FAIL run%0d_retire%0d got pc=%0d en=%b f=%b xr=%b nxt=%0d want %0d/%b/%b/%b/%0d",
                     tag, idx, a0, env, ef, xr, bus.rom_addr,
                     tr_pc[idx], exp_en, exp_f, exp_x, tr_next[idx]);
          end
        end
        idx++;
      end else if ({env, ef, xr} !== 6'b0) begin
        mismatched++;
        $display("FAIL run%0d_idle_enable pc=%0d got en=%b f=%b xr=%b want 0", tag, a0, env, ef, xr);
      end
    end
    bus.x_valid = 1'b0;
    compared++;
    if (halted !== 1'b1) begin
      mismatched++;
      $display("FAIL run%0d_timeout got halted=%b want 1", tag, halted);
    end
    compared++;
    if (idx != tr_pc.size() || instr_cnt !== 16'(tr_pc.size())) begin
      mismatched++;
      $display("FAIL run%0d_count got retires=%0d cnt=%0d want %0d", tag, idx, instr_cnt, tr_pc.size());
    end
  endtask

  task automatic test_full_run();
    fill_rom(0, 1);
    do_reset();
    run_program(1'($urandom_range(0, 1)), 0);
    compared++;
    if (instr_cnt !== 16'd32) begin
      mismatched++;
      $display("FAIL run_no_jump_cnt got %0d want 32", instr_cnt);
    end
    for (int t = 1; t <= 3; t++) begin
      fill_rom(1, 1);
      run_program(1'(t == 3), t);
    end
  endtask

  task automatic test_stop_fetch();
    logic [3:0] want_en;
    fill_rom(0, 0);
    run_mode = 1'b1;
    do_reset();
    want_en = 4'b0001 << rom[0][1:0];
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0; #1;
    compared++;
    if (en_vec() !== want_en || bus.en_flags !== 1'b1) begin
      mismatched++;
      $display("FAIL stop_retire got en=%b f=%b want %b/1", en_vec(), bus.en_flags, want_en);
    end
    tick(); #1;
    compared++;
    if (halted !== 1'b1 || busy !== 1'b0 || instr_cnt !== 16'd1 || bus.rom_addr !== 5'd1) begin
      mismatched++;
      $display("FAIL stop_halt got halted=%b busy=%b cnt=%0d pc=%0d want 1/0/1/1",
               halted, busy, instr_cnt, bus.rom_addr);
    end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; #1;
    compared++;
    if (busy !== 1'b1 || bus.rom_addr !== 5'd0 || instr_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL restart got busy=%b pc=%0d cnt=%0d want 1/0/0", busy, bus.rom_addr, instr_cnt);
    end
    tick();
    reset = 1'b1; #1;
    compared++;
    if (en_vec() !== 4'b0 || bus.en_flags !== 1'b0 || bus.x_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_exec_enables got en=%b f=%b xr=%b want 0000/0/0",
               en_vec(), bus.en_flags, bus.x_ready);
    end
    tick(); reset = 1'b0; #1;
    compared++;
    if (busy !== 1'b0 || halted !== 1'b0 || bus.rom_addr !== 5'd0 || instr_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_exec_state got busy=%b halted=%b pc=%0d cnt=%0d want 0/0/0/0",
               busy, halted, bus.rom_addr, instr_cnt);
    end
  endtask

  initial begin
    bus.x_valid = 1'b0;
    bus.flag_z = 1'b0;
    test_reset();
    test_first_fetch();
    test_jump();
    test_x_stall();
    test_single_step();
    test_full_run();
    test_stop_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
